// File: rtl/aes_pkg.sv
// Shared AES datapath package: forward/inverse S-box tables,
// 128-bit state type and the SubBytes engine FSM encoding.
package aes_pkg;

  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [7:0] sbox_fwd(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

  function automatic logic [7:0] sbox_inv(
    input logic [7:0] b
  );
    return INV_SBOX[b];
  endfunction

endpackage

// File: rtl/sub_bytes_engine_if.sv
// Valid/ready bundle for the SubBytes engine: input state
// channel (in_*) and substituted-state channel (out_*).
interface sub_bytes_engine_if;
  import aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_data;
  logic   out_valid;
  logic   out_ready;
  state_t out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/aes_sbox.sv
// Single-byte combinational forward AES S-box lookup.
// Ports: a (byte in), y (S(a) out).
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_fwd(a);

endmodule

// File: rtl/sub_bytes_engine.sv
// Forward SubBytes engine: LANES bytes per cycle, ITER cycles/state.
// Ports: clk, rst (sync, active high), bus (slave side of the bundle).
module sub_bytes_engine
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  sub_bytes_engine_if.slave bus
);

  localparam int ITER = 16 / LANES;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  fsm_e          st;
  logic [CW-1:0] cnt;
  state_t        state_q;
  state_t        state_d;

  logic [7:0] cur    [16];
  logic [7:0] nxt    [16];
  logic [7:0] sb_in  [LANES];
  logic [7:0] sb_out [LANES];
  logic [3:0] base;

  logic accept;
  logic step;
  logic drain;

  assign bus.in_ready  = (st == IDLE) |
                         ((st == DONE) & bus.out_ready);
  assign bus.out_valid = (st == DONE);
  assign bus.out_data  = state_q;

  assign accept = bus.in_valid & bus.in_ready;
  assign step   = (st == BUSY);
  assign drain  = (st == DONE) & bus.out_ready &
                  ~bus.in_valid;

  // Byte 0 sits in the MSBs of the state word.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cur[i] = state_q[127-8*i -: 8];
    end
  end

  assign base = 4'(int'(cnt) * LANES);

  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      sb_in[j] = cur[base + 4'(j)];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    aes_sbox u_sbox (
      .a (sb_in[g]),
      .y (sb_out[g])
    );
  end

  // Only the current lane window is rewritten.
  always_comb begin
    for (int i = 0; i < 16; i++) begin
      nxt[i] = cur[i];
    end
    for (int j = 0; j < LANES; j++) begin
      nxt[base + 4'(j)] = sb_out[j];
    end
  end

  always_comb begin
    state_d = '0;
    for (int i = 0; i < 16; i++) begin
      state_d[127-8*i -: 8] = nxt[i];
    end
  end

  // accept covers both IDLE and the DONE same-edge reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= IDLE;
      cnt     <= '0;
      state_q <= '0;
    end else begin
      unique case (1'b1)
        accept: begin
          state_q <= bus.in_data;
          cnt     <= '0;
          st      <= BUSY;
        end
        step: begin
          state_q <= state_d;
          if (cnt == LAST) begin
            cnt <= '0;
            st  <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        drain: begin
          st <= IDLE;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Self-checking bench for sub_bytes_engine with a GF(2^8) reference
// model, directed reset/backpressure cases and a LANES sweep.
module tb_sub_bytes_engine;
  import aes_pkg::*;

  localparam int ITER4 = 4;
  localparam logic [127:0] VEC =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] VEC_S =
    128'h638293c31bfc33f5c4eeacea4bc12816;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   armed = 1'b0;

  logic [7:0] mtab [256];

  initial forever #5 clk = ~clk;

  sub_bytes_engine_if bus4 ();

  sub_bytes_engine #(.LANES(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  logic         sw_valid = 1'b0;
  logic         sw_ready = 1'b1;
  logic [127:0] sw_data  = '0;
  logic [3:0]   sw_ov;
  logic [3:0]   sw_ir;
  logic [127:0] sw_od [4];

  for (genvar g = 0; g < 4; g++) begin : g_sw
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 :
                       (g == 2) ? 8 : 16;
    sub_bytes_engine_if sif ();
    assign sif.in_valid  = sw_valid;
    assign sif.in_data   = sw_data;
    assign sif.out_ready = sw_ready;
    assign sw_ov[g] = sif.out_valid;
    assign sw_ir[g] = sif.in_ready;
    assign sw_od[g] = sif.out_data;
    sub_bytes_engine #(.LANES(L)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (sif.slave)
    );
  end

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b
  );
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] v);
    logic [7:0] s = v;
    logic [7:0] r = v;
    for (int k = 0; k < 4; k++) begin
      r = {r[6:0], r[7]};
      s = s ^ r;
    end
    return s ^ 8'h63;
  endfunction

  task automatic build_model();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] iv = '0;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      end
      mtab[x] = affine(iv);
    end
  endtask

  function automatic logic [127:0] model_sub(
    input logic [127:0] s
  );
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = mtab[s[127-8*i -: 8]];
    end
    return r;
  endfunction

  function automatic logic [127:0] inv_state(
    input logic [127:0] s
  );
    logic [127:0] r = '0;
    for (int i = 0; i < 16; i++) begin
      r[127-8*i -: 8] = sbox_inv(s[127-8*i -: 8]);
    end
    return r;
  endfunction

  task automatic chk(
    input string nm,
    input logic [127:0] act,
    input logic [127:0] exp
  );
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Reference model: one state in flight, result due ITER edges
  // after acceptance, held until the consumer takes it.
  bit           m_busy = 1'b0;
  int           m_age  = 0;
  logic [127:0] m_exp  = '0;
  logic [127:0] m_orig = '0;
  int           n_done = 0;

  initial forever begin
    logic e_ov;
    logic e_ir;
    @(negedge clk);
    if (rst) begin
      m_busy = 1'b0;
    end else if (armed) begin
      e_ov = m_busy && (m_age >= ITER4);
      e_ir = !m_busy || (e_ov && bus4.out_ready);
      chk("out_valid", 128'(bus4.out_valid), 128'(e_ov));
      chk("in_ready", 128'(bus4.in_ready), 128'(e_ir));
      if (e_ov) chk("out_data", bus4.out_data, m_exp);
      if (e_ov && bus4.out_ready) begin
        chk("round_trip", inv_state(bus4.out_data), m_orig);
        n_done++;
        m_busy = 1'b0;
      end
      if (bus4.in_valid && e_ir) begin
        m_busy = 1'b1;
        m_age  = 0;
        m_exp  = model_sub(bus4.in_data);
        m_orig = bus4.in_data;
      end else if (m_busy) begin
        m_age++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_one(input logic [127:0] d);
    int g = 0;
    bus4.in_valid = 1'b1;
    bus4.in_data  = d;
    #1;
    while (!bus4.in_ready && g < 50) begin
      step();
      g++;
    end
    if (!bus4.in_ready)
      chk("accept_ready", 128'(bus4.in_ready), 128'(1));
    step();
    bus4.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!bus4.out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int base;
    int cyc;
    int first [4];
    logic [127:0] got [4];
    int exp_lat [4] = '{16, 8, 2, 1};
    logic [127:0] d;
    logic [127:0] v2;
    logic [127:0] v3;

    build_model();
    chk("model_s00", 128'(mtab[8'h00]), 128'(8'h63));
    chk("model_s01", 128'(mtab[8'h01]), 128'(8'h7c));
    chk("model_s53", 128'(mtab[8'h53]), 128'(8'hed));
    chk("model_sff", 128'(mtab[8'hff]), 128'(8'h16));
    chk("model_vec", model_sub(VEC), VEC_S);
    chk("inv_vec", inv_state(VEC_S), VEC);

    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    armed = 1'b1;
    chk("rst_in_ready", 128'(bus4.in_ready), 128'(1));
    chk("rst_out_valid", 128'(bus4.out_valid), 128'(0));
    chk("rst_out_data", bus4.out_data, 128'(0));

    send_one(VEC);
    wait_out(lat);
    chk("vec_latency", 128'(lat), 128'(4));
    chk("vec_data", bus4.out_data, VEC_S);
    step();

    for (int s = 0; s < 16; s++) begin
      for (int i = 0; i < 16; i++) begin
        d[127-8*i -: 8] = 8'(16 * s + i);
      end
      send_one(d);
      wait_out(lat);
      chk("sweep_latency", 128'(lat), 128'(4));
    end
    step();

    v2 = {$urandom, $urandom, $urandom, $urandom};
    v3 = {$urandom, $urandom, $urandom, $urandom};
    bus4.out_ready = 1'b0;
    send_one(v2);
    wait_out(lat);
    chk("bp_latency", 128'(lat), 128'(4));
    for (int c = 0; c < 10; c++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = {$urandom, $urandom, $urandom, $urandom};
      step();
      chk("bp_in_ready", 128'(bus4.in_ready), 128'(0));
      chk("bp_hold", bus4.out_data, model_sub(v2));
    end
    bus4.in_data   = v3;
    bus4.out_ready = 1'b1;
    #1;
    chk("bp_ready_follow", 128'(bus4.in_ready), 128'(1));
    step();
    bus4.in_valid = 1'b0;
    chk("bp_reaccept", 128'(bus4.out_valid), 128'(0));
    wait_out(lat);
    chk("bp_next_latency", 128'(lat), 128'(4));
    chk("bp_next_data", bus4.out_data, model_sub(v3));
    step();

    send_one(VEC);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_in_ready", 128'(bus4.in_ready), 128'(1));
    chk("mid_out_valid", 128'(bus4.out_valid), 128'(0));
    chk("mid_out_data", bus4.out_data, 128'(0));
    repeat (6) step();
    send_one(VEC);
    wait_out(lat);
    chk("mid_latency", 128'(lat), 128'(4));
    chk("mid_data", bus4.out_data, VEC_S);
    step();

    sw_ready = 1'b1;
    sw_data  = VEC;
    sw_valid = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk("lanes_in_ready", 128'(sw_ir[g]), 128'(1));
      first[g] = 0;
      got[g]   = '0;
    end
    step();
    sw_valid = 1'b0;
    for (int e = 1; e <= 24; e++) begin
      step();
      for (int g = 0; g < 4; g++) begin
        if (sw_ov[g] && first[g] == 0) begin
          first[g] = e;
          got[g]   = sw_od[g];
        end
      end
    end
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("lanes_latency_%0d", g),
          128'(first[g]), 128'(exp_lat[g]));
      chk($sformatf("lanes_data_%0d", g), got[g], VEC_S);
    end

    base = n_done;
    cyc  = 0;
    while (n_done < base + 1000 && cyc < 60000) begin
      bus4.in_valid  = ($urandom_range(0, 3) != 0);
      bus4.in_data   = {$urandom, $urandom, $urandom, $urandom};
      bus4.out_ready = ($urandom_range(0, 3) != 0);
      step();
      cyc++;
    end
    chk("random_count", 128'(n_done - base), 128'(1000));
    bus4.in_valid  = 1'b0;
    bus4.out_ready = 1'b1;
    repeat (10) step();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
